// File: rtl/axis_adder_arbiter.sv
// -----------------------------------------------------------------------------
// axis_adder_arbiter
//
// Purpose
//   Shares a single AXI-Stream adder between N_REQ AXI-Stream requesters.
//   One operand pair is granted at a time. It is forwarded to the adder. The
//   adder result is returned on the granted requester's response channel.
//   Only one operation is in flight at any time:
//   IDLE -> ISSUE -> WAIT -> RETURN -> IDLE.
//
// Configuration
//   AXIS_ARB_RR_EN  defined   : round-robin arbitration. The search starts at
//                               rr_ptr. The pointer advances past the last
//                               grantee when its response completes.
//                   undefined : fixed priority. The lowest valid index wins.
//
// Parameters
//   DATA_WIDTH  operand / result width (must match the adder)
//   N_REQ       number of requesters, 2..16
//   ID_WIDTH    width of grant_id, clog2(N_REQ)
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active-low
//   s_req_tdata   packed {a,b} per requester, slice i at [i*2*DW +: 2*DW]
//   s_req_tvalid  request valid per requester
//   s_req_tready  request ready, at most one bit set
//   m_rsp_tdata   result bus shared by all requesters
//   m_rsp_tvalid  response valid, one-hot or zero
//   m_rsp_tready  response ready per requester
//   m_add_tdata   operands to adder
//   m_add_tvalid  operand valid to adder
//   m_add_tready  operand ready from adder
//   s_add_tdata   result from adder
//   s_add_tvalid  result valid from adder
//   s_add_tready  result ready to adder
//   busy          high whenever the FSM is not in IDLE
//   grant_id      index of the current or most recent grantee
// -----------------------------------------------------------------------------
module axis_adder_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ*2*DATA_WIDTH-1:0]   s_req_tdata,
    input  logic [N_REQ-1:0]                s_req_tvalid,
    output logic [N_REQ-1:0]                s_req_tready,
    output logic [DATA_WIDTH-1:0]           m_rsp_tdata,
    output logic [N_REQ-1:0]                m_rsp_tvalid,
    input  logic [N_REQ-1:0]                m_rsp_tready,
    output logic [2*DATA_WIDTH-1:0]         m_add_tdata,
    output logic                            m_add_tvalid,
    input  logic                            m_add_tready,
    input  logic [DATA_WIDTH-1:0]           s_add_tdata,
    input  logic                            s_add_tvalid,
    output logic                            s_add_tready,
    output logic                            busy,
    output logic [ID_WIDTH-1:0]             grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Per-requester operand slices.
    logic [2*DATA_WIDTH-1:0] req_data [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_data[i] = s_req_tdata[i*2*DATA_WIDTH +: 2*DATA_WIDTH];
    end

    // Arbitration result.
    logic [ID_WIDTH-1:0] arb_start;
    logic [ID_WIDTH-1:0] arb_sel;
    logic                arb_found;

    // FSM strobes.
    logic accept;
    logic issue_done;
    logic result_take;
    logic rsp_done;

    // Searches vld starting at index start, ascending with wrap. The first
    // set bit wins. Returns {found, index}.
    function automatic logic [ID_WIDTH:0] arb_pick(
        input logic [N_REQ-1:0]    vld,
        input logic [ID_WIDTH-1:0] start
    );
        logic                found;
        logic [ID_WIDTH-1:0] idx;
        logic [ID_WIDTH-1:0] cand;
        int                  j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(start) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = ID_WIDTH'(j);
            if (!found && vld[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

`ifdef AXIS_ARB_RR_EN
    logic [ID_WIDTH-1:0] rr_ptr;
    assign arb_start = rr_ptr;
`else
    assign arb_start = '0;
`endif

    assign {arb_found, arb_sel} = arb_pick(s_req_tvalid, arb_start);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        next_state   = state;
        s_req_tready = '0;
        s_add_tready = 1'b0;
        accept       = 1'b0;
        issue_done   = 1'b0;
        result_take  = 1'b0;
        rsp_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                // Ready here drains and discards a result left over from an
                // operation that a reset abandoned.
                s_add_tready = 1'b1;
                // rst gating keeps request ready low for the whole reset.
                if (rst && arb_found) begin
                    s_req_tready = N_REQ'(1) << arb_sel;
                    accept       = 1'b1;
                    next_state   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_add_tready) begin
                    issue_done = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                s_add_tready = 1'b1;
                if (s_add_tvalid) begin
                    result_take = 1'b1;
                    next_state  = ST_RETURN;
                end
            end
            ST_RETURN: begin
                // Ready bits of requesters that were not granted are ignored.
                if (m_rsp_tready[grant_id]) begin
                    rsp_done   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Operand, grant and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_add_tdata  <= '0;
            m_add_tvalid <= 1'b0;
            grant_id     <= '0;
            m_rsp_tdata  <= '0;
            m_rsp_tvalid <= '0;
        end else begin
            if (accept) begin
                m_add_tdata  <= req_data[arb_sel];
                grant_id     <= arb_sel;
                m_add_tvalid <= 1'b1;
            end
            if (issue_done) begin
                m_add_tvalid <= 1'b0;
            end
            if (result_take) begin
                m_rsp_tdata  <= s_add_tdata;
                m_rsp_tvalid <= N_REQ'(1) << grant_id;
            end
            if (rsp_done) begin
                m_rsp_tvalid <= '0;
            end
        end
    end

`ifdef AXIS_ARB_RR_EN
    // The pointer moves past the grantee only when its response completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (rsp_done) begin
            if (grant_id == ID_WIDTH'(N_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_id + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_adder_arbiter
//   Bench for axis_adder_arbiter.
//   It includes a behavioural adder with a programmable result latency.
//   It applies a table of single operations, then arbitration, backpressure,
//   adder-stall and reset-during-operation sequences.
// -----------------------------------------------------------------------------
module tb_axis_adder_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*2*DW-1:0] s_req_tdata;
    logic [N-1:0]      s_req_tvalid;
    logic [N-1:0]      s_req_tready;
    logic [DW-1:0]     m_rsp_tdata;
    logic [N-1:0]      m_rsp_tvalid;
    logic [N-1:0]      m_rsp_tready;
    logic [2*DW-1:0]   m_add_tdata;
    logic              m_add_tvalid;
    logic              m_add_tready;
    logic [DW-1:0]     s_add_tdata  = '0;
    logic              s_add_tvalid = 1'b0;
    logic              s_add_tready;
    logic              busy;
    logic [IW-1:0]     grant_id;

    logic [2*DW-1:0]   rd [N];
    assign s_req_tdata = {rd[3], rd[2], rd[1], rd[0]};

    always #5 clk = ~clk;

    axis_adder_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .ID_WIDTH(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_req_tdata  (s_req_tdata),
        .s_req_tvalid (s_req_tvalid),
        .s_req_tready (s_req_tready),
        .m_rsp_tdata  (m_rsp_tdata),
        .m_rsp_tvalid (m_rsp_tvalid),
        .m_rsp_tready (m_rsp_tready),
        .m_add_tdata  (m_add_tdata),
        .m_add_tvalid (m_add_tvalid),
        .m_add_tready (m_add_tready),
        .s_add_tdata  (s_add_tdata),
        .s_add_tvalid (s_add_tvalid),
        .s_add_tready (s_add_tready),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    // Behavioural adder. A latency of 0 presents the sum on the edge after
    // the operand handshake. The adder is not reset by rst, so a result can
    // outlive an arbiter reset.
    int            add_lat = 0;
    int            cnt     = 0;
    logic          pend    = 1'b0;
    logic [DW-1:0] psum    = '0;

    always @(posedge clk) begin
        if (s_add_tvalid && s_add_tready) s_add_tvalid <= 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                s_add_tvalid <= 1'b1;
                s_add_tdata  <= psum;
                pend         <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (m_add_tvalid && m_add_tready) begin
            if (add_lat == 0) begin
                s_add_tvalid <= 1'b1;
                s_add_tdata  <= DW'(m_add_tdata[15:8] + m_add_tdata[7:0]);
            end else begin
                pend <= 1'b1;
                cnt  <= add_lat - 1;
                psum <= DW'(m_add_tdata[15:8] + m_add_tdata[7:0]);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_rsp(input string nm);
        int n = 0;
        while (m_rsp_tvalid == '0 && n < 20) begin
            tick;
            n++;
        end
        chk({nm, " rsp_seen"}, 32'(m_rsp_tvalid != '0), 32'd1);
    endtask

    task automatic wait_acc(input string nm);
        int n = 0;
        while (s_req_tready == '0 && n < 20) begin
            tick;
            n++;
        end
        chk({nm, " acc_seen"}, 32'(s_req_tready != '0), 32'd1);
    endtask

    // One isolated operation from requester id with immediate response ready.
    task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] sum, input string nm);
        logic [N-1:0] oh;
        oh = N'(1) << id;
        rd[id]       = {a, b};
        s_req_tvalid = oh;
        #1;
        chk({nm, " req_tready"}, 32'(s_req_tready), 32'(oh));
        tick;
        s_req_tvalid = '0;
        chk({nm, " add_tdata"}, 32'(m_add_tdata), 32'({a, b}));
        chk({nm, " add_tvalid"}, 32'(m_add_tvalid), 32'd1);
        chk({nm, " grant_id"}, 32'(grant_id), 32'(id));
        chk({nm, " busy"}, 32'(busy), 32'd1);
        wait_rsp(nm);
        chk({nm, " rsp_tvalid"}, 32'(m_rsp_tvalid), 32'(oh));
        chk({nm, " rsp_tdata"}, 32'(m_rsp_tdata), 32'(sum));
        tick;
        chk({nm, " rsp_clear"}, 32'(m_rsp_tvalid), 32'd0);
        chk({nm, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
    } vec_t;

    vec_t vt [5];
    int   exp_ord [5];

    initial begin
        vt[0] = '{id: 1, a: 8'h03, b: 8'h04, sum: 8'h07};
        vt[1] = '{id: 0, a: 8'hF0, b: 8'h20, sum: 8'h10};
        vt[2] = '{id: 2, a: 8'hFF, b: 8'h01, sum: 8'h00};
        vt[3] = '{id: 3, a: 8'h7F, b: 8'h80, sum: 8'hFF};
        vt[4] = '{id: 2, a: 8'h12, b: 8'h34, sum: 8'h46};
`ifdef AXIS_ARB_RR_EN
        exp_ord = '{0, 1, 2, 3, 0};
`else
        exp_ord = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < N; i++) rd[i] = '0;

        // Reset state, with requests pending that must not be acknowledged.
        rst          = 1'b0;
        s_req_tvalid = 4'b0110;
        m_rsp_tready = 4'hF;
        m_add_tready = 1'b1;
        #12;
        chk("rst req_tready", 32'(s_req_tready), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst rsp_tvalid", 32'(m_rsp_tvalid), 32'd0);
        chk("rst add_tvalid", 32'(m_add_tvalid), 32'd0);
        chk("rst grant_id", 32'(grant_id), 32'd0);
        chk("rst rsp_tdata", 32'(m_rsp_tdata), 32'd0);
        chk("rst add_tdata", 32'(m_add_tdata), 32'd0);
        s_req_tvalid = '0;
        tick;
        rst = 1'b1;
        tick;

        // Single operations, including mod-2^DW wrap.
        for (int i = 0; i < 5; i++) begin
            run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].sum, $sformatf("vec%0d", i));
        end

        // All requesters valid continuously.
        do_reset;
        for (int i = 0; i < N; i++) rd[i] = {8'(i + 1), 8'(16 * (i + 1))};
        s_req_tvalid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_acc($sformatf("arb%0d", k));
            tick;
            chk($sformatf("arb%0d grant", k), 32'(grant_id), 32'(exp_ord[k]));
            wait_rsp($sformatf("arb%0d", k));
            chk($sformatf("arb%0d data", k), 32'(m_rsp_tdata), 32'(8'(17 * (exp_ord[k] + 1))));
            tick;
        end
        s_req_tvalid = '0;
        tick;

        // Response backpressure on requester 2, while requester 0 waits.
        rd[2]        = {8'h05, 8'h06};
        rd[0]        = {8'h01, 8'h01};
        m_rsp_tready = 4'b1011;
        s_req_tvalid = 4'b0100;
        tick;
        s_req_tvalid = 4'b0001;
        wait_rsp("bp");
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d rsp_tvalid", c), 32'(m_rsp_tvalid), 32'h4);
            chk($sformatf("bp%0d rsp_tdata", c), 32'(m_rsp_tdata), 32'h0B);
            chk($sformatf("bp%0d busy", c), 32'(busy), 32'd1);
            chk($sformatf("bp%0d req_tready", c), 32'(s_req_tready), 32'd0);
            tick;
        end
        m_rsp_tready = 4'hF;
        tick;
        chk("bp release", 32'(m_rsp_tvalid), 32'd0);
        chk("bp next_ready", 32'(s_req_tready), 32'h1);
        s_req_tvalid = '0;
        tick;

        // Adder stall for three cycles.
        m_add_tready = 1'b0;
        rd[3]        = {8'h40, 8'h02};
        s_req_tvalid = 4'b1000;
        tick;
        s_req_tvalid = '0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d add_tvalid", c), 32'(m_add_tvalid), 32'd1);
            chk($sformatf("stall%0d add_tdata", c), 32'(m_add_tdata), 32'h4002);
            tick;
        end
        m_add_tready = 1'b1;
        wait_rsp("stall");
        chk("stall rsp_tvalid", 32'(m_rsp_tvalid), 32'h8);
        chk("stall rsp_tdata", 32'(m_rsp_tdata), 32'h42);
        tick;

        // Reset while waiting on a slow adder.
        add_lat      = 4;
        rd[1]        = {8'h09, 8'h09};
        s_req_tvalid = 4'b0010;
        tick;
        s_req_tvalid = '0;
        tick;
        chk("mid busy_wait", 32'(busy), 32'd1);
        rst          = 1'b0;
        s_req_tvalid = 4'b0001;
        #1;
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst add_tvalid", 32'(m_add_tvalid), 32'd0);
        chk("mid rst rsp_tvalid", 32'(m_rsp_tvalid), 32'd0);
        chk("mid rst grant_id", 32'(grant_id), 32'd0);
        chk("mid rst add_tdata", 32'(m_add_tdata), 32'd0);
        chk("mid rst rsp_tdata", 32'(m_rsp_tdata), 32'd0);
        chk("mid rst req_tready", 32'(s_req_tready), 32'd0);
        tick;
        s_req_tvalid = '0;
        rst          = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick;
            chk($sformatf("late%0d no_rsp", c), 32'({m_rsp_tvalid, busy}), 32'd0);
        end
        chk("late drained", 32'(s_add_tvalid), 32'd0);
        add_lat = 0;
        run_op(0, 8'h01, 8'h02, 8'h03, "recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
